// File: rtl/fw_ip_cfg_chain.sv
// Configuration-chain engine: software fills a word buffer, execute shifts it into the
// DUT chain on a divided clock, captures the chain output and then pulses fw_config_load.
module fw_ip_cfg_chain #(
   parameter int CHAIN_BITS = 768,
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 16
) (
   input  logic        fw_clk,
   input  logic        fw_rst,
   input  logic        fw_dev_id_enable,
   input  logic        fw_op_code_w_reset,
   input  logic        fw_op_code_w_cfg_array_0,
   input  logic        fw_op_code_r_cfg_array_0,
   input  logic        fw_op_code_w_status_clear,
   input  logic        fw_op_code_w_execute,
   input  logic        fw_op_code_r_data_array_0,
   input  logic [23:0] sw_write24_0,
   output logic [31:0] fw_read_data32,
   output logic [31:0] fw_read_status32,
   output logic        fw_config_clk,
   output logic        fw_config_in,
   output logic        fw_config_load,
   output logic        fw_reset_not,
   input  logic        fw_config_out
);
   localparam int NWORDS  = (CHAIN_BITS + 23) / 24;
   localparam int PW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int CNT_MAX = (2 * CLK_DIV > RST_CYCLES) ? 2 * CLK_DIV : RST_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2, DUTRST = 2'd3} state_t;

   state_t          state, state_nxt;
   logic [23:0]     wbuf [NWORDS];
   logic [23:0]     rbuf [NWORDS];
   logic [PW-1:0]   wr_ptr, rd_ptr, word_idx, word_nxt;
   logic [4:0]      bit_idx, bit_nxt;
   logic [12:0]     bit_cnt;
   logic [CW-1:0]   cnt;
   logic            busy, done, err;
   logic            op_rst, op_clr, op_exec, op_wr, op_rcfg, op_rdat;
   logic            div_end, load_end, rst_end, last_bit, capture;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      op_rst  = 1'b0;
      op_clr  = 1'b0;
      op_exec = 1'b0;
      op_wr   = 1'b0;
      op_rcfg = 1'b0;
      op_rdat = 1'b0;
      if (fw_dev_id_enable) begin
         if (fw_op_code_w_reset)               op_rst  = 1'b1;
         else if (fw_op_code_w_status_clear)   op_clr  = 1'b1;
         else if (fw_op_code_w_execute)        op_exec = 1'b1;
         else if (fw_op_code_w_cfg_array_0)    op_wr   = 1'b1;
         else if (fw_op_code_r_cfg_array_0)    op_rcfg = 1'b1;
         else if (fw_op_code_r_data_array_0)   op_rdat = 1'b1;
      end
   end

   assign div_end  = (cnt == CW'(CLK_DIV - 1));
   assign load_end = (cnt == CW'(2 * CLK_DIV - 1));
   assign rst_end  = (cnt == CW'(RST_CYCLES - 1));
   assign last_bit = (bit_cnt == 13'(CHAIN_BITS - 1));
   assign word_nxt = word_idx + PW'(1);
   assign bit_nxt  = bit_idx + 5'd1;
   assign capture  = (state == SHIFT) && div_end && !fw_config_clk && !op_rst;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (op_exec) state_nxt = SHIFT;
         SHIFT:   if (div_end && fw_config_clk && last_bit) state_nxt = LOAD;
         LOAD:    if (load_end) state_nxt = IDLE;
         DUTRST:  if (rst_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (op_rst) state_nxt = DUTRST;
   end

   // NOTE: both buffers are reset so never-shifted upper bits read back as zero; this
   // keeps them in flops rather than a RAM macro.
   always_ff @(posedge fw_clk or posedge fw_rst) begin
      if (fw_rst) begin
         for (int i = 0; i < NWORDS; i++) begin
            wbuf[i] <= '0;
            rbuf[i] <= '0;
         end
      end else begin
         if (op_wr && state == IDLE) wbuf[wr_ptr] <= sw_write24_0;
         if (capture) rbuf[word_idx][bit_idx] <= fw_config_out;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values and later statements in this block override earlier ones.
   always_ff @(posedge fw_clk or posedge fw_rst) begin
      if (fw_rst) begin
         state            <= IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         err              <= 1'b0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         word_idx         <= '0;
         bit_idx          <= '0;
         bit_cnt          <= '0;
         cnt              <= '0;
         fw_config_clk    <= 1'b0;
         fw_config_in     <= 1'b0;
         fw_config_load   <= 1'b1;
         fw_reset_not     <= 1'b1;
         fw_read_data32   <= '0;
         fw_read_status32 <= '0;
      end else begin
         state            <= state_nxt;
         fw_read_status32 <= {8'h0, 8'(rd_ptr), 8'(wr_ptr), 3'b0, state, err, done, busy};

         if (op_rst) begin
            busy           <= 1'b0;
            cnt            <= '0;
            fw_config_clk  <= 1'b0;
            fw_config_load <= 1'b1;
            fw_reset_not   <= 1'b0;
         end else begin
            case (state)
               IDLE: if (op_exec) begin
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  bit_cnt       <= '0;
                  word_idx      <= '0;
                  bit_idx       <= '0;
                  cnt           <= '0;
                  fw_config_clk <= 1'b0;
                  fw_config_in  <= wbuf[0][0];
               end
               SHIFT: if (!div_end) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  cnt <= '0;
                  if (!fw_config_clk) begin
                     fw_config_clk <= 1'b1;
                  end else begin
                     fw_config_clk <= 1'b0;
                     if (last_bit) begin
                        fw_config_load <= 1'b0;
                     end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                        if (bit_idx == 5'd23) begin
                           bit_idx      <= '0;
                           word_idx     <= word_nxt;
                           fw_config_in <= wbuf[word_nxt][0];
                        end else begin
                           bit_idx      <= bit_nxt;
                           fw_config_in <= wbuf[word_idx][bit_nxt];
                        end
                     end
                  end
               end
               LOAD: if (load_end) begin
                  fw_config_load <= 1'b1;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  wr_ptr         <= '0;
                  rd_ptr         <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
               DUTRST: if (rst_end) fw_reset_not <= 1'b1;
                       else cnt <= cnt + CW'(1);
               default: ;
            endcase

            if (op_clr) begin
               done <= 1'b0;
               err  <= 1'b0;
               if (state == IDLE) begin
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end
            end
            if (op_exec && state != IDLE) err <= 1'b1;
            if (op_wr) begin
               if (state == IDLE) wr_ptr <= (wr_ptr == PW'(NWORDS - 1)) ? '0 : wr_ptr + PW'(1);
               else err <= 1'b1;
            end
            if (op_rcfg || op_rdat) begin
               fw_read_data32 <= {8'h0, op_rcfg ? wbuf[rd_ptr] : rbuf[rd_ptr]};
               rd_ptr         <= (rd_ptr == PW'(NWORDS - 1)) ? '0 : rd_ptr + PW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_fw_ip_cfg_chain.sv
// Directed bench: instance a has a 48-bit looped-back chain (CLK_DIV=2), instance b a
// 30-bit chain whose output is tied high (CLK_DIV=1). Opcodes are shared, enables are not.
module tb_fw_ip_cfg_chain;
   localparam logic [5:0] OP_RST  = 6'b000001;
   localparam logic [5:0] OP_WR   = 6'b000010;
   localparam logic [5:0] OP_RCFG = 6'b000100;
   localparam logic [5:0] OP_CLR  = 6'b001000;
   localparam logic [5:0] OP_EXEC = 6'b010000;
   localparam logic [5:0] OP_RDAT = 6'b100000;

   logic        fw_clk = 1'b0;
   logic        fw_rst = 1'b1;
   logic        en_a = 1'b0, en_b = 1'b0;
   logic [5:0]  ops = '0;
   logic [23:0] wdata = '0;
   logic [31:0] rd_a, st_a, rd_b, st_b;
   logic        cclk_a, cin_a, load_a, rstn_a, cout_a;
   logic        cclk_b, cin_b, load_b, rstn_b;
   logic        cout_b = 1'b1;
   logic [47:0] chain = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 fw_clk = ~fw_clk;

   // 48-stage DUT chain model clocked by the divided configuration clock
   always @(posedge cclk_a) chain <= {chain[46:0], cin_a};
   assign cout_a = chain[47];

   fw_ip_cfg_chain #(.CHAIN_BITS(48), .CLK_DIV(2), .RST_CYCLES(16)) dut_a (
      .fw_clk(fw_clk), .fw_rst(fw_rst), .fw_dev_id_enable(en_a),
      .fw_op_code_w_reset(ops[0]), .fw_op_code_w_cfg_array_0(ops[1]),
      .fw_op_code_r_cfg_array_0(ops[2]), .fw_op_code_w_status_clear(ops[3]),
      .fw_op_code_w_execute(ops[4]), .fw_op_code_r_data_array_0(ops[5]),
      .sw_write24_0(wdata), .fw_read_data32(rd_a), .fw_read_status32(st_a),
      .fw_config_clk(cclk_a), .fw_config_in(cin_a), .fw_config_load(load_a),
      .fw_reset_not(rstn_a), .fw_config_out(cout_a));

   fw_ip_cfg_chain #(.CHAIN_BITS(30), .CLK_DIV(1), .RST_CYCLES(16)) dut_b (
      .fw_clk(fw_clk), .fw_rst(fw_rst), .fw_dev_id_enable(en_b),
      .fw_op_code_w_reset(ops[0]), .fw_op_code_w_cfg_array_0(ops[1]),
      .fw_op_code_r_cfg_array_0(ops[2]), .fw_op_code_w_status_clear(ops[3]),
      .fw_op_code_w_execute(ops[4]), .fw_op_code_r_data_array_0(ops[5]),
      .sw_write24_0(wdata), .fw_read_data32(rd_b), .fw_read_status32(st_b),
      .fw_config_clk(cclk_b), .fw_config_in(cin_b), .fw_config_load(load_b),
      .fw_reset_not(rstn_b), .fw_config_out(cout_b));

   // Strobe one opcode set for one cycle; returns at the negedge of the cycle after it.
   task automatic op(input logic [5:0] o, input logic a, input logic b, input logic [23:0] d);
      ops = o; en_a = a; en_b = b; wdata = d;
      @(negedge fw_clk);
      ops = '0; en_a = 1'b0; en_b = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge fw_clk);
   endtask

   task automatic wait_done(input logic sel_b, input int budget, input string tag);
      int n = 0;
      logic [31:0] s;
      @(negedge fw_clk);
      s = sel_b ? st_b : st_a;
      while (!(s[0] == 1'b0 && s[1] == 1'b1) && n < budget) begin
         @(negedge fw_clk);
         n++;
         s = sel_b ? st_b : st_a;
      end
      checks++;
      if (n >= budget) begin errors++; $display("FAIL %s_wait_done: status=%h after %0d cycles, expected busy=0 done=1", tag, s, n); end
   endtask

   task automatic test_reset();
      tick(2);
      fw_rst = 1'b0;
      tick(1);
      checks++; if ({cclk_a, cin_a, load_a, rstn_a} !== 4'b0011) begin errors++; $display("FAIL reset_pins_a: got %b expected 0011", {cclk_a, cin_a, load_a, rstn_a}); end
      checks++; if ({cclk_b, cin_b, load_b, rstn_b} !== 4'b0011) begin errors++; $display("FAIL reset_pins_b: got %b expected 0011", {cclk_b, cin_b, load_b, rstn_b}); end
      checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_data_a: got %h expected 0", rd_a); end
      checks++; if (st_a !== 32'h0) begin errors++; $display("FAIL reset_status_a: got %h expected 0", st_a); end
      checks++; if (rd_b !== 32'h0) begin errors++; $display("FAIL reset_data_b: got %h expected 0", rd_b); end
      checks++; if (st_b !== 32'h0) begin errors++; $display("FAIL reset_status_b: got %h expected 0", st_b); end
   endtask

   task automatic test_gating();
      op(OP_WR, 1'b0, 1'b0, 24'h123456);
      op(OP_EXEC, 1'b0, 1'b0, 24'h0);
      tick(1);
      checks++; if (st_a !== 32'h0) begin errors++; $display("FAIL gated_ops: status %h expected 0", st_a); end
      op(OP_EXEC | OP_WR, 1'b1, 1'b0, 24'h654321);
      tick(1);
      checks++; if (st_a !== 32'h0000_0009) begin errors++; $display("FAIL exec_beats_write: status %h expected 00000009", st_a); end
      wait_done(1'b0, 300, "gating");
      checks++; if (st_a !== 32'h0000_0002) begin errors++; $display("FAIL gating_done: status %h expected 00000002", st_a); end
      op(OP_CLR, 1'b0, 1'b0, 24'h0);
      tick(1);
      checks++; if (st_a !== 32'h0000_0002) begin errors++; $display("FAIL gated_clear: status %h expected 00000002", st_a); end
      op(OP_RCFG, 1'b1, 1'b0, 24'h0);
      checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL dropped_write: wbuf[0] %h expected 0", rd_a); end
   endtask

   task automatic test_shift_capture();
      int nrise = 0, first_rise = -1, last_rise = 0, bad_period = 0, bad_in = 0;
      int fall_c = -1, rise_c = -1, done_c = -1;
      logic prev_clk, prev_load, prev_in;
      op(OP_CLR, 1'b1, 1'b0, 24'h0);
      op(OP_WR, 1'b1, 1'b0, 24'hA5A5A5);
      op(OP_WR, 1'b1, 1'b0, 24'h0F0F0F);
      op(OP_EXEC, 1'b1, 1'b0, 24'h0);
      checks++; if ({cclk_a, cin_a} !== 2'b01) begin errors++; $display("FAIL first_bit: clk,in %b expected 01", {cclk_a, cin_a}); end
      prev_clk = 1'b0; prev_load = 1'b1; prev_in = cin_a;
      for (int c = 1; c <= 205; c++) begin
         if (cclk_a && !prev_clk) begin
            nrise++;
            if (first_rise < 0) first_rise = c;
            else if (c - last_rise != 4) bad_period++;
            last_rise = c;
         end
         if (c > 1 && cin_a !== prev_in && !(prev_clk && !cclk_a)) bad_in++;
         if (!load_a && prev_load) fall_c = c;
         if (load_a && !prev_load) rise_c = c;
         if (st_a[1] && done_c < 0) done_c = c;
         prev_clk = cclk_a; prev_load = load_a; prev_in = cin_a;
         @(negedge fw_clk);
      end
      checks++; if (nrise != 48) begin errors++; $display("FAIL clk_pulses: got %0d expected 48", nrise); end
      checks++; if (first_rise != 3) begin errors++; $display("FAIL first_rise: cycle %0d expected 3", first_rise); end
      checks++; if (bad_period != 0) begin errors++; $display("FAIL clk_period: %0d periods differ from 4, expected 0", bad_period); end
      checks++; if (bad_in != 0) begin errors++; $display("FAIL cfg_in_timing: %0d bad changes, expected 0", bad_in); end
      checks++; if (fall_c != 193) begin errors++; $display("FAIL load_fall: cycle %0d expected 193", fall_c); end
      checks++; if (rise_c != 197) begin errors++; $display("FAIL load_rise: cycle %0d expected 197", rise_c); end
      checks++; if (done_c != 198) begin errors++; $display("FAIL done_cycle: cycle %0d expected 198", done_c); end
      op(OP_RDAT, 1'b1, 1'b0, 24'h0);
      checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL empty_chain_read: got %h expected 0", rd_a); end
      op(OP_EXEC, 1'b1, 1'b0, 24'h0);
      wait_done(1'b0, 300, "capture");
      op(OP_RDAT, 1'b1, 1'b0, 24'h0);
      checks++; if (rd_a !== 32'h00A5A5A5) begin errors++; $display("FAIL capture_w0: got %h expected 00A5A5A5", rd_a); end
      op(OP_RDAT, 1'b1, 1'b0, 24'h0);
      checks++; if (rd_a !== 32'h000F0F0F) begin errors++; $display("FAIL capture_w1: got %h expected 000F0F0F", rd_a); end
   endtask

   task automatic test_illegal_busy();
      op(OP_EXEC, 1'b1, 1'b0, 24'h0);
      tick(10);
      op(OP_WR, 1'b1, 1'b0, 24'h123456);
      tick(1);
      checks++; if (st_a !== 32'h0000_000D) begin errors++; $display("FAIL write_while_busy: status %h expected 0000000D", st_a); end
      op(OP_EXEC, 1'b1, 1'b0, 24'h0);
      tick(1);
      checks++; if (st_a !== 32'h0000_000D) begin errors++; $display("FAIL exec_while_busy: status %h expected 0000000D", st_a); end
      op(OP_CLR, 1'b1, 1'b0, 24'h0);
      tick(1);
      checks++; if (st_a !== 32'h0000_0009) begin errors++; $display("FAIL clear_while_busy: status %h expected 00000009", st_a); end
      wait_done(1'b0, 300, "illegal");
      checks++; if (st_a !== 32'h0000_0002) begin errors++; $display("FAIL illegal_done: status %h expected 00000002", st_a); end
      op(OP_RCFG, 1'b1, 1'b0, 24'h0);
      checks++; if (rd_a !== 32'h00A5A5A5) begin errors++; $display("FAIL wbuf_kept_w0: got %h expected 00A5A5A5", rd_a); end
      op(OP_RCFG, 1'b1, 1'b0, 24'h0);
      checks++; if (rd_a !== 32'h000F0F0F) begin errors++; $display("FAIL wbuf_kept_w1: got %h expected 000F0F0F", rd_a); end
      op(OP_RDAT, 1'b1, 1'b0, 24'h0);
      checks++; if (rd_a !== 32'h00A5A5A5) begin errors++; $display("FAIL illegal_capture: got %h expected 00A5A5A5", rd_a); end
   endtask

   task automatic test_abort();
      int low = 0, load_low = 0;
      op(OP_EXEC, 1'b1, 1'b0, 24'h0);
      tick(42);
      checks++; if (cclk_a !== 1'b1) begin errors++; $display("FAIL bit10_high_phase: clk %b expected 1", cclk_a); end
      op(OP_RST, 1'b1, 1'b0, 24'h0);
      checks++; if ({cclk_a, rstn_a, load_a} !== 3'b001) begin errors++; $display("FAIL abort_pins: clk,rstn,load %b expected 001", {cclk_a, rstn_a, load_a}); end
      for (int c = 0; c < 40; c++) begin
         if (!rstn_a) low++;
         if (!load_a) load_low++;
         @(negedge fw_clk);
      end
      checks++; if (low != 16) begin errors++; $display("FAIL reset_width: %0d cycles low expected 16", low); end
      checks++; if (load_low != 0) begin errors++; $display("FAIL abort_load: %0d load-low cycles expected 0", load_low); end
      checks++; if (st_a !== 32'h0001_0000) begin errors++; $display("FAIL abort_status: status %h expected 00010000", st_a); end
   endtask

   task automatic test_wrap();
      op(OP_WR, 1'b0, 1'b1, 24'h111111);
      op(OP_WR, 1'b0, 1'b1, 24'h222222);
      op(OP_WR, 1'b0, 1'b1, 24'h333333);
      tick(1);
      checks++; if (st_b[15:8] !== 8'd1) begin errors++; $display("FAIL wrap_wr_ptr: got %0d expected 1", st_b[15:8]); end
      op(OP_RCFG, 1'b0, 1'b1, 24'h0);
      checks++; if (rd_b !== 32'h00333333) begin errors++; $display("FAIL wrap_w0: got %h expected 00333333", rd_b); end
      op(OP_RCFG, 1'b0, 1'b1, 24'h0);
      checks++; if (rd_b !== 32'h00222222) begin errors++; $display("FAIL wrap_w1: got %h expected 00222222", rd_b); end
      op(OP_EXEC, 1'b0, 1'b1, 24'h0);
      wait_done(1'b1, 200, "wrap");
      op(OP_RDAT, 1'b0, 1'b1, 24'h0);
      checks++; if (rd_b !== 32'h00FFFFFF) begin errors++; $display("FAIL partial_w0: got %h expected 00FFFFFF", rd_b); end
      op(OP_RDAT, 1'b0, 1'b1, 24'h0);
      checks++; if (rd_b !== 32'h0000003F) begin errors++; $display("FAIL partial_w1: got %h expected 0000003F", rd_b); end
   endtask

   task automatic test_async_reset_load();
      int n = 0;
      op(OP_EXEC, 1'b1, 1'b0, 24'h0);
      while (load_a !== 1'b0 && n < 300) begin
         @(negedge fw_clk);
         n++;
      end
      checks++; if (n >= 300) begin errors++; $display("FAIL load_wait: load never fell in %0d cycles", n); end
      tick(1);
      checks++; if (load_a !== 1'b0) begin errors++; $display("FAIL mid_load: load %b expected 0", load_a); end
      #2 fw_rst = 1'b1;
      #1;
      checks++; if (load_a !== 1'b1) begin errors++; $display("FAIL async_load: load %b expected 1", load_a); end
      checks++; if (st_a !== 32'h0) begin errors++; $display("FAIL async_status: status %h expected 0", st_a); end
      checks++; if ({cclk_a, rstn_a, rd_a} !== {2'b01, 32'h0}) begin errors++; $display("FAIL async_pins: clk,rstn %b data %h expected 01 / 0", {cclk_a, rstn_a}, rd_a); end
      @(negedge fw_clk);
      fw_rst = 1'b0;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_gating();
      test_shift_capture();
      test_illegal_busy();
      test_abort();
      test_wrap();
      test_async_reset_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/fw_ip_cfg_chain.md
# fw_ip_cfg_chain

Parametrised configuration-chain engine that takes over the DUT-side config and reset pins from the stub-level `fw_ip` slots. Software fills a word buffer through the common SW-to-FW opcode decode. An execute opcode serially shifts the buffer into the DUT configuration chain on a divided `fw_config_clk` and captures `fw_config_out` into a readback buffer, then pulses `fw_config_load`. Status and readback words return over the existing 32-bit read paths.

## Interface
- `CHAIN_BITS`, default 768: configuration chain length in bits, range 1..6144.
- `CLK_DIV`, default 4: `fw_config_clk` half-period in `fw_clk` cycles, minimum 1.
- `RST_CYCLES`, default 16: width of the `fw_reset_not` low pulse in `fw_clk` cycles.
- Derived: `NWORDS` = ceil(CHAIN_BITS/24), at most 256; `PW` = max(1, clog2(NWORDS)).
- `fw_clk`  in  1  FW clock.
- `fw_rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `fw_dev_id_enable`  in  1  qualifies every opcode input; opcodes are ignored while it is low.
- `fw_op_code_w_reset`, `fw_op_code_w_cfg_array_0`, `fw_op_code_r_cfg_array_0`, `fw_op_code_w_status_clear`, `fw_op_code_w_execute`, `fw_op_code_r_data_array_0`  in  1 each  single-cycle opcode strobes.
- `sw_write24_0`  in  24  write data.
- `fw_read_data32`  out  32  readback word.
- `fw_read_status32`  out  32  status word.
- `fw_config_clk`, `fw_config_in`, `fw_config_load`, `fw_reset_not`  out  1 each  DUT configuration pins.
- `fw_config_out`  in  1  DUT chain serial output, synchronous to `fw_clk`.

## Operation
- Opcode priority when several are valid in one cycle: w_reset > w_status_clear > w_execute > w_cfg_array_0 > r_cfg_array_0 / r_data_array_0. Only the winning opcode takes effect.
- States: IDLE, SHIFT, LOAD, DUTRST.
- **w_cfg_array_0** (IDLE only):
  - `wbuf[wr_ptr] <= sw_write24_0`; `wr_ptr` increments and wraps from NWORDS-1 to 0.
  - In any other state the write is dropped and `err` is set.
- **w_execute**:
  - From IDLE: go to SHIFT, set busy, clear done, zero `bit_cnt`.
  - From any other state: ignored and `err` is set.
- **SHIFT**:
  - Chain bit k is `wbuf[k/24][k%24]`; bit 0 is shifted first.
  - Per bit: `fw_config_in` is driven with `fw_config_clk` low for CLK_DIV cycles, then `fw_config_clk` is high for CLK_DIV cycles.
  - On the cycle `fw_config_clk` rises, `fw_config_out` is sampled into `rbuf[k/24][k%24]`.
  - After bit CHAIN_BITS-1 completes its high phase, go to LOAD.
  - Unused upper bits of the last word are never shifted and read back as 0.
- **LOAD**: `fw_config_load` = 0 for 2*CLK_DIV cycles, then 1. Then go to IDLE, clear busy, set done, and reset `wr_ptr` and `rd_ptr` to 0.
- **w_reset** from any state:
  - Aborts SHIFT or LOAD and enters DUTRST: `fw_reset_not` = 0 for RST_CYCLES cycles, then IDLE.
  - `fw_config_clk` = 0 and `fw_config_load` = 1 immediately.
  - `done` is not set; buffers are kept.
- **w_status_clear**: clears `done` and `err`. Pointers are zeroed only if the state is IDLE.
- **r_cfg_array_0**: `fw_read_data32 <= {8'h0, wbuf[rd_ptr]}`; `rd_ptr` increments and wraps.
- **r_data_array_0**: same as r_cfg_array_0, but returns `rbuf[rd_ptr]`.
- Reads are allowed in any state. A read of `rbuf` during SHIFT returns partially updated data.
- `fw_read_status32` bit fields:
  - [0] busy
  - [1] done
  - [2] err
  - [4:3] state (IDLE=0, SHIFT=1, LOAD=2, DUTRST=3)
  - [15:8] `wr_ptr`
  - [23:16] `rd_ptr`
  - [31:24] 0
- `bit_cnt` is 13 bits; no arithmetic overflows within the parameter range.

## Timing
- Reset values:
  - `fw_config_clk` = 0, `fw_config_in` = 0, `fw_config_load` = 1, `fw_reset_not` = 1.
  - `fw_read_data32` = 0, `fw_read_status32` = 0.
  - Pointers, flags and both buffers are 0; state is IDLE.
- Asserting `fw_rst` mid-SHIFT aborts immediately to these values.
- All outputs are registered.
- Writes land one cycle after the strobe.
- `fw_read_data32` is valid the cycle after a read strobe and holds until the next read.
- The status word lags internal state by one cycle.
- Execute accepted at cycle 0:
  - Bit 0 appears on `fw_config_in` at cycle 1, with `fw_config_clk` low.
  - The first rising edge of `fw_config_clk` is at cycle 1+CLK_DIV.
  - `fw_config_load` falls at cycle 1 + 2·CLK_DIV·CHAIN_BITS.
  - `fw_config_load` rises and busy clears 2·CLK_DIV cycles after it falls.
  - Done is visible in status one cycle after busy clears.
- `fw_config_in` changes only on the cycle `fw_config_clk` falls, or at SHIFT entry.

## Test plan
- **Shift and capture.** CHAIN_BITS=48, CLK_DIV=2. Write 24'hA5A5A5 then 24'h0F0F0F; tie `fw_config_out` to `fw_config_in` delayed by 48 bits (chain model); execute. Required: 48 clock pulses of period 4; LOAD low pulse of 4 cycles; done=1 at cycle 198; on a second execute, r_data_array_0 ×2 returns A5A5A5, 0F0F0F.
- **Wrap-around and read pointer.** CHAIN_BITS=30. Write 3 words. Required: word 2 overwrites word 0; wr_ptr=1. r_cfg_array_0 ×2 returns word2 value then word1 value. Readback bits [23:6] of word 1 = 0.
- **Illegal opcodes while busy.** Write and execute during SHIFT. Required: err=1, wbuf unchanged, shift completes normally. status_clear during SHIFT clears err, busy stays 1.
- **Abort via w_reset.** w_reset at bit 10 of SHIFT. Required: `fw_config_clk`=0 next cycle, `fw_reset_not` low for exactly 16 cycles, state IDLE afterwards, done=0, no `fw_config_load` pulse.
- **Async reset mid-LOAD.** Assert `fw_rst` mid-LOAD. Required: `fw_config_load`=1 and status=0 without waiting for a clock edge.
- **Opcode gating and priority.** Opcodes with `fw_dev_id_enable`=0 have no effect. execute + write in the same cycle: execute wins and the write is dropped without setting err.
